// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters.
// It runs the master's strobe/ready handshake and aborts transfers that hang.
`timescale 1ns/1ps
module spi_xfer_arbiter #(
    parameter int NREQ    = 4,
    parameter int SSW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                Clk_i,
    input  logic                Rst_i,
    input  logic [NREQ-1:0]     Req_i,
    input  logic [NREQ*8-1:0]   Data_i,
    input  logic [NREQ*SSW-1:0] Ss_i,
    output logic [NREQ-1:0]     Gnt_o,
    output logic [NREQ-1:0]     Done_o,
    output logic [NREQ-1:0]     Err_o,
    output logic [7:0]          Rdata_o,
    output logic [7:0]          MBuf_o,
    output logic [SSW-1:0]      MSs_o,
    output logic                MStrobe_o,
    input  logic                MReady_i,
    input  logic [7:0]          MRcvd_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT, DONE} stateT;

    stateT          state;
    logic [IW-1:0]  rr;
    logic [IW-1:0]  idx;
    logic [CW-1:0]  cnt;

    logic           pickValid;
    logic [IW-1:0]  pickIdx;
    logic [NREQ-1:0] pickOneHot;
    logic [7:0]     pickData;
    logic [SSW-1:0] pickSs;
    logic           pickLegal;

    function automatic logic isOneHot(input logic [SSW-1:0] m);
        return (m != '0) && ((m & (m - SSW'(1))) == '0);
    endfunction

    function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    // Scan offsets from farthest to nearest so the requester closest to rr wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (Req_i[(int'(rr) + k) % NREQ]) begin
                pickValid = 1'b1;
                pickIdx   = IW'((int'(rr) + k) % NREQ);
            end
        end
        pickOneHot = NREQ'(1) << pickIdx;
        pickData   = Data_i[int'(pickIdx)*8 +: 8];
        pickSs     = Ss_i[int'(pickIdx)*SSW +: SSW];
        pickLegal  = isOneHot(pickSs);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state     <= IDLE;
            rr        <= '0;
            idx       <= '0;
            cnt       <= '0;
            Gnt_o     <= '0;
            Done_o    <= '0;
            Err_o     <= '0;
            Rdata_o   <= '0;
            MBuf_o    <= '0;
            MSs_o     <= '0;
            MStrobe_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        idx   <= pickIdx;
                        Gnt_o <= pickOneHot;
                        if (pickLegal) begin
                            MBuf_o <= pickData;
                            MSs_o  <= pickSs;
                        end else begin
                            Err_o <= pickOneHot;
                        end
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // An illegal mask was flagged on capture; abort without strobing.
                    if (Err_o != '0) begin
                        Err_o <= '0;
                        Gnt_o <= '0;
                        rr    <= nextIdx(idx);
                        state <= IDLE;
                    end else begin
                        MStrobe_o <= 1'b1;
                        state     <= STROBE;
                    end
                end
                STROBE: begin
                    MStrobe_o <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (MReady_i) begin
                        Rdata_o <= MRcvd_i;
                        Done_o  <= Gnt_o;
                        state   <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 2)) begin
                        Err_o <= Gnt_o;
                        state <= DONE;
                    end
                end
                DONE: begin
                    Done_o <= '0;
                    Err_o  <= '0;
                    Gnt_o  <= '0;
                    MSs_o  <= '0;
                    rr     <= nextIdx(idx);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: directed vectors, multi-cycle corner
// sequences and an end-to-end run against a behavioural master with two slaves.
`timescale 1ns/1ps
module tb_spi_xfer_arbiter;

    localparam int NREQ    = 4;
    localparam int SSW     = 2;
    localparam int TIMEOUT = 64;

    logic        tbClk;
    logic        tbRst;
    logic [3:0]  Req;
    logic [31:0] Data;
    logic [7:0]  Ss;
    logic [3:0]  Gnt_o, Done_o, Err_o;
    logic [7:0]  Rdata_o, MBuf_o;
    logic [1:0]  MSs_o;
    logic        MStrobe_o;
    logic        MReady;
    logic [7:0]  MRcvd;

    logic        manReady, autoReady;
    logic [7:0]  manRcvd, autoRcvd;

    logic        autoEn, slaveSwap;
    int          respDelay;
    logic [7:0]  slaveMem [2];
    logic [7:0]  sentBuf;
    int          sentSel;

    assign MReady = manReady | autoReady;
    assign MRcvd  = autoReady ? autoRcvd : manRcvd;

    spi_xfer_arbiter #(.NREQ(NREQ), .SSW(SSW), .TIMEOUT(TIMEOUT)) dut (
        .Clk_i(tbClk), .Rst_i(tbRst), .Req_i(Req), .Data_i(Data), .Ss_i(Ss),
        .Gnt_o(Gnt_o), .Done_o(Done_o), .Err_o(Err_o), .Rdata_o(Rdata_o),
        .MBuf_o(MBuf_o), .MSs_o(MSs_o), .MStrobe_o(MStrobe_o),
        .MReady_i(MReady), .MRcvd_i(MRcvd)
    );

    initial tbClk = 1'b0;
    always #5 tbClk = ~tbClk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    // Behavioural master + two exchange-style slaves: each slave returns its
    // held byte and keeps the byte it was sent.
    initial begin
        autoReady   = 1'b0;
        autoRcvd    = 8'h00;
        slaveMem[0] = 8'h5A;
        slaveMem[1] = 8'hC3;
        sentBuf     = 8'h00;
        sentSel     = 0;
        forever begin
            @(posedge tbClk); #1;
            if (autoEn && MStrobe_o) begin
                sentBuf = MBuf_o;
                sentSel = MSs_o[1] ? 1 : 0;
                repeat (respDelay) @(posedge tbClk);
                #1;
                autoReady = 1'b1;
                autoRcvd  = slaveMem[sentSel];
                if (slaveSwap) slaveMem[sentSel] = sentBuf;
                @(posedge tbClk); #1;
                autoReady = 1'b0;
            end
        end
    end

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge tbClk); #1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  ss;
        int          d;
        logic [7:0]  rcvd;
        logic [3:0]  expGnt;
        logic        legal;
        logic [7:0]  expBuf;
        logic [1:0]  expSs;
    } vecT;

    vecT vecs [8];

    task automatic runVec(input int i);
        vecT v;
        v = vecs[i];
        Req = v.req; Data = v.data; Ss = v.ss;
        step();
        check($sformatf("v%0d gnt", i), 32'(Gnt_o), 32'(v.expGnt));
        check($sformatf("v%0d err", i), 32'(Err_o), v.legal ? 32'd0 : 32'(v.expGnt));
        check($sformatf("v%0d mss", i), 32'(MSs_o), v.legal ? 32'(v.expSs) : 32'd0);
        if (!v.legal) Req = 4'b0000;
        step();
        check($sformatf("v%0d strobe", i), 32'(MStrobe_o), 32'(v.legal));
        if (v.legal) begin
            check($sformatf("v%0d mbuf", i), 32'(MBuf_o), 32'(v.expBuf));
            for (int c = 0; c < v.d; c++) begin
                step();
                if (c == 0) check($sformatf("v%0d strobe width", i), 32'(MStrobe_o), 32'd0);
            end
            manReady = 1'b1; manRcvd = v.rcvd;
            step();
            manReady = 1'b0;
            check($sformatf("v%0d done", i), 32'(Done_o), 32'(v.expGnt));
            check($sformatf("v%0d rdata", i), 32'(Rdata_o), 32'(v.rcvd));
            check($sformatf("v%0d err at done", i), 32'(Err_o), 32'd0);
            Req = 4'b0000;
            step();
            check($sformatf("v%0d gnt drop", i), 32'(Gnt_o), 32'd0);
            check($sformatf("v%0d mss release", i), 32'(MSs_o), 32'd0);
        end else begin
            check($sformatf("v%0d gnt drop", i), 32'(Gnt_o), 32'd0);
            check($sformatf("v%0d err width", i), 32'(Err_o), 32'd0);
        end
    endtask

    initial begin
        int         errAt, nGr, k, s;
        logic       errSeen, got;
        logic [3:0] order [5];
        logic [3:0] prevGnt;
        logic [7:0] b;
        logic [31:0] dw;
        logic [7:0] sw;
        logic [7:0] expSlave [2];

        vecs[0] = '{4'b0001, 32'h0000_00A5, 8'b00_00_00_01, 1, 8'h3C, 4'b0001, 1'b1, 8'hA5, 2'b01};
        vecs[1] = '{4'b0001, 32'hDEAD_BE11, 8'b11_00_11_10, 3, 8'h22, 4'b0001, 1'b1, 8'h11, 2'b10};
        vecs[2] = '{4'b1010, 32'h1234_7756, 8'b00_00_01_11, 2, 8'h88, 4'b0010, 1'b1, 8'h77, 2'b01};
        vecs[3] = '{4'b0011, 32'hAB01_CD9E, 8'b01_01_01_10, 4, 8'h01, 4'b0001, 1'b1, 8'h9E, 2'b10};
        vecs[4] = '{4'b0100, 32'h0033_0000, 8'b00_11_01_01, 1, 8'h00, 4'b0100, 1'b0, 8'h00, 2'b00};
        vecs[5] = '{4'b1000, 32'h5500_0000, 8'b00_01_01_01, 1, 8'h00, 4'b1000, 1'b0, 8'h00, 2'b00};
        vecs[6] = '{4'b1100, 32'h00F0_0000, 8'b01_10_00_00, 5, 8'hFF, 4'b0100, 1'b1, 8'hF0, 2'b10};
        vecs[7] = '{4'b1111, 32'h4200_0000, 8'b01_00_00_00, 2, 8'h5C, 4'b1000, 1'b1, 8'h42, 2'b01};

        tbRst = 1'b1; Req = 4'b0000; Data = 32'h0; Ss = 8'h0;
        manReady = 1'b0; manRcvd = 8'h00;
        autoEn = 1'b0; slaveSwap = 1'b0; respDelay = 1;
        step(); step();
        check("reset gnt", 32'(Gnt_o), 32'd0);
        check("reset done", 32'(Done_o), 32'd0);
        check("reset err", 32'(Err_o), 32'd0);
        check("reset rdata", 32'(Rdata_o), 32'd0);
        check("reset mbuf", 32'(MBuf_o), 32'd0);
        check("reset mss", 32'(MSs_o), 32'd0);
        check("reset strobe", 32'(MStrobe_o), 32'd0);
        tbRst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) runVec(i);

        // Stray ready in IDLE must leave everything untouched.
        manReady = 1'b1; manRcvd = 8'hEE;
        step();
        manReady = 1'b0;
        check("stray done", 32'(Done_o), 32'd0);
        check("stray err", 32'(Err_o), 32'd0);
        check("stray rdata", 32'(Rdata_o), 32'h5C);
        step();
        check("stray gnt", 32'(Gnt_o), 32'd0);

        // Timeout on requester 0, then requester 1 served with ready on the last legal cycle.
        Req = 4'b0011; Data = 32'h0000_2211; Ss = 8'b00_00_01_01;
        step();
        check("to gnt0", 32'(Gnt_o), 32'b0001);
        errAt = 0;
        for (int c = 2; c <= 80; c++) begin
            step();
            if (Err_o != 4'b0000) begin errAt = c; break; end
        end
        check("to latency", 32'(errAt), 32'(2 + TIMEOUT));
        check("to err", 32'(Err_o), 32'b0001);
        check("to no done", 32'(Done_o), 32'd0);
        check("to gnt held", 32'(Gnt_o), 32'b0001);
        Req = 4'b0010;
        step();
        check("to gnt drop", 32'(Gnt_o), 32'd0);
        check("to mss release", 32'(MSs_o), 32'd0);
        step();
        check("to next gnt", 32'(Gnt_o), 32'b0010);
        errSeen = 1'b0;
        for (int c = 2; c <= TIMEOUT + 1; c++) begin
            step();
            if (Err_o != 4'b0000) errSeen = 1'b1;
        end
        manReady = 1'b1; manRcvd = 8'h6B;
        step();
        manReady = 1'b0;
        check("edge no early err", 32'(errSeen), 32'd0);
        check("edge done", 32'(Done_o), 32'b0010);
        check("edge err", 32'(Err_o), 32'd0);
        check("edge rdata", 32'(Rdata_o), 32'h6B);
        Req = 4'b0000;
        step();

        // Reset while waiting for the master.
        Req = 4'b0100; Data = 32'h0099_0000; Ss = 8'b00_01_00_00;
        repeat (5) step();
        tbRst = 1'b1;
        step();
        check("rst gnt", 32'(Gnt_o), 32'd0);
        check("rst done", 32'(Done_o), 32'd0);
        check("rst err", 32'(Err_o), 32'd0);
        check("rst rdata", 32'(Rdata_o), 32'd0);
        check("rst mbuf", 32'(MBuf_o), 32'd0);
        check("rst mss", 32'(MSs_o), 32'd0);
        check("rst strobe", 32'(MStrobe_o), 32'd0);
        tbRst = 1'b0;
        Req = 4'b0110; Data = 32'h0099_3100; Ss = 8'b00_01_01_00;
        step();
        check("rst rr gnt", 32'(Gnt_o), 32'b0010);
        check("rst no done", 32'(Done_o), 32'd0);
        check("rst no err", 32'(Err_o), 32'd0);
        step(); step();
        manReady = 1'b1; manRcvd = 8'h17;
        step();
        manReady = 1'b0;
        check("rst xfer done", 32'(Done_o), 32'b0010);
        check("rst xfer rdata", 32'(Rdata_o), 32'h17);
        Req = 4'b0000;
        step();

        // Round-robin with all requesters held.
        tbRst = 1'b1;
        step();
        tbRst = 1'b0;
        Req = 4'b1111; Data = 32'h4433_2211; Ss = 8'b01_10_01_10;
        autoEn = 1'b1; slaveSwap = 1'b0; respDelay = 10;
        nGr = 0; prevGnt = 4'b0000;
        for (int c = 0; c < 400 && nGr < 5; c++) begin
            step();
            if (Gnt_o != 4'b0000 && prevGnt == 4'b0000) begin
                order[nGr] = Gnt_o;
                nGr++;
            end
            prevGnt = Gnt_o;
        end
        check("rr grant count", 32'(nGr), 32'd5);
        check("rr grant 0", 32'(order[0]), 32'b0001);
        check("rr grant 1", 32'(order[1]), 32'b0010);
        check("rr grant 2", 32'(order[2]), 32'b0100);
        check("rr grant 3", 32'(order[3]), 32'b1000);
        check("rr grant 4", 32'(order[4]), 32'b0001);
        for (int c = 0; c < 40; c++) begin
            if (Done_o != 4'b0000) break;
            step();
        end
        Req = 4'b0000;
        step(); step();

        // End-to-end random transfers through the behavioural master and slaves.
        expSlave[0] = 8'h5A;
        expSlave[1] = 8'hC3;
        slaveSwap = 1'b1;
        void'($urandom(32'd2024));
        for (int t = 0; t < 100; t++) begin
            k  = int'($urandom_range(0, 3));
            s  = int'($urandom_range(0, 1));
            b  = 8'($urandom_range(0, 255));
            dw = $urandom();
            dw[k*8 +: 8] = b;
            sw = 8'($urandom());
            sw[k*2 +: 2] = (s == 1) ? 2'b10 : 2'b01;
            respDelay = int'($urandom_range(1, 20));
            Data = dw; Ss = sw; Req = 4'(1 << k);
            got = 1'b0;
            for (int c = 0; c < 60; c++) begin
                step();
                if (Done_o != 4'b0000 || Err_o != 4'b0000) begin got = 1'b1; break; end
            end
            check($sformatf("e2e%0d done", t), 32'(Done_o), 32'(1 << k));
            check($sformatf("e2e%0d gnt", t), 32'(Gnt_o), 32'(1 << k));
            check($sformatf("e2e%0d rdata", t), 32'(Rdata_o), 32'(expSlave[s]));
            check($sformatf("e2e%0d slave byte", t), 32'(sentBuf), 32'(b));
            check($sformatf("e2e%0d slave sel", t), 32'(sentSel), 32'(s));
            if (got) expSlave[s] = b;
            Req = 4'b0000;
            step();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
